imem_load_ctrl: RTL

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/cpu_pkg.sv | 16 +
 rtl/word_assembler.sv | 35 +++
 rtl/imem_load_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: program-loader state encoding and default address width.
package cpu_pkg;

    localparam int ADDR_W_DEF = 14;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } load_state_t;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler: first byte received lands in bits 7:0.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_done
);

    logic [31:0] word_q;
    logic [1:0]  byte_cnt;

    // Shift right so that after four bytes the first one has reached the bottom lane.
    assign word_next = {byte_in, word_q[31:8]};
    assign word_done = byte_valid && (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= 2'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (byte_valid) begin
            word_q <= word_next;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// UART program loader: receives a 16-bit word count then little-endian words,
// writes them into instruction memory and holds the CPU in reset meanwhile.
module imem_load_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_mode,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_we,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    load_state_t       state, state_nxt;
    logic [15:0]       len_n;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              counting, tmo_hit, last_word;
    logic              asm_clear, asm_valid, asm_done;
    logic [31:0]       asm_word_next;

    assign len_full  = {rx_byte, len_n[7:0]};
    assign counting  = state inside {LEN_LO, LEN_HI, DATA};
    assign tmo_hit   = counting && !rx_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign last_word = (32'(word_cnt) + 32'd1) == {16'd0, len_n};
    assign asm_clear = (state == RUN);
    assign asm_valid = (state == DATA) && rx_valid && load_mode;

    // CPU owns the memory port while running; the loader owns it otherwise.
    assign imem_addr = (state == RUN) ? cpu_addr : wr_addr;

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_byte),
        .word_next  (asm_word_next),
        .word_done  (asm_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:    if (load_mode) state_nxt = LEN_LO;
            LEN_LO: begin
                if (!load_mode || tmo_hit) state_nxt = ERR;
                else if (rx_valid)         state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (!load_mode || tmo_hit) state_nxt = ERR;
                else if (rx_valid) begin
                    if (len_full == 16'd0)                   state_nxt = DONE;
                    else if ({16'd0, len_full} > MAX_WORDS) state_nxt = ERR;
                    else                                     state_nxt = DATA;
                end
            end
            DATA: begin
                if (!load_mode || tmo_hit) state_nxt = ERR;
                else if (asm_done)         state_nxt = WRITE;
            end
            // A byte arriving while the word is being written cannot be buffered.
            WRITE: begin
                if (!load_mode || rx_valid) state_nxt = ERR;
                else if (last_word)         state_nxt = DONE;
                else                        state_nxt = DATA;
            end
            DONE, ERR: if (!load_mode) state_nxt = RUN;
            default:   state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            cpu_rst_n  <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            imem_we    <= 1'b0;
            imem_wdata <= 32'd0;
            len_n      <= 16'd0;
            word_cnt   <= '0;
            wr_addr    <= '0;
            tmo_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            cpu_rst_n <= (state == RUN);
            busy      <= (state_nxt != RUN);
            load_done <= (state_nxt == DONE);
            load_err  <= (state_nxt == ERR);
            imem_we   <= (state_nxt == WRITE);

            if (state == DATA && state_nxt == WRITE) imem_wdata <= asm_word_next;
            if (state == LEN_LO && state_nxt == LEN_HI) len_n[7:0] <= rx_byte;
            if (state == LEN_HI && rx_valid) len_n[15:8] <= rx_byte;

            // Address stops on the last word so a full-size image never wraps it.
            if (state == RUN) begin
                word_cnt <= '0;
                wr_addr  <= '0;
            end else if (state == WRITE) begin
                word_cnt <= word_cnt + (ADDR_W + 1)'(1);
                if (!last_word) wr_addr <= wr_addr + ADDR_W'(1);
            end

            if (state_nxt != state || rx_valid || !counting) tmo_cnt <= '0;
            else                                             tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

endmodule
